call_stack: RTL and testbench
=============================

# call_stack

Hardware return stack for `call m` / `ret`. It holds the return PC and ALU flags pushed by the control unit on `call` and returns them on `ret`. It sits beside the control unit and is driven only by it: the control unit issues push/pop strobes and consumes the top-of-stack outputs. The stack depth is fixed at build time, with a default of 5 entries. Overflow and underflow are flagged and never corrupt the stored contents.

## Interface
Parameters:
- `DEPTH`, 5: number of entries (≥2).
- `PC_WIDTH`, 8: width of a stored program counter.
- `FLAGS_WIDTH`, 4: width of stored ALU flags; matches the ALU flag bus.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_push`, in, 1: push `in_pc`/`in_flags` this cycle.
- `in_pop`, in, 1: pop the top entry this cycle.
- `in_clear`, in, 1: synchronous flush plus error clear.
- `in_pc`, in, PC_WIDTH: return PC to push.
- `in_flags`, in, FLAGS_WIDTH: flags to push.
- `out_top_pc`, out, PC_WIDTH: PC of the top entry; 0 when empty.
- `out_top_flags`, out, FLAGS_WIDTH: flags of the top entry; 0 when empty.
- `out_depth`, out, $clog2(DEPTH+1): number of valid entries.
- `out_empty`, out, 1: high when `out_depth == 0`.
- `out_full`, out, 1: high when `out_depth == DEPTH`.
- `out_overflow`, out, 1: sticky; a push was dropped.
- `out_underflow`, out, 1: sticky; a pop was dropped.

## Operation
- Storage: DEPTH entries of {pc, flags}, plus a stack pointer `sp` in the range 0..DEPTH. `sp` equals the number of valid entries, and the top entry is `sp-1`.
- Top outputs are combinational reads of the registered state, with no added latency. When empty they read 0.
- Command priority per cycle: `in_clear` takes priority over push/pop.
- Clear: `sp` becomes 0 and both sticky errors become 0. Entry contents need not be zeroed.
- Push only:
  - Not full: write entry `sp`, then `sp` increments.
  - Full: no write, `sp` is unchanged, and `out_overflow` is set to 1.
- Pop only:
  - Not empty: `sp` decrements.
  - Empty: `sp` is unchanged and `out_underflow` is set to 1.
- Push and pop together:
  - Not empty: replace the top entry with the input; `sp` is unchanged and no error is raised. This holds when full as well.
  - Empty: the push is performed, `sp` becomes 1, and `out_underflow` is set to 1.
- Neither push nor pop: all state holds.
- Sticky errors stay set until `in_clear` or reset.
- No wrap-around: `sp` saturates at 0 and at DEPTH, and it never aliases entries.

## Timing
- All state updates on the rising edge of `clk`. Status and top outputs reflect the new state in the same cycle after that edge.
- The `ret` sequence in the control unit:
  - It samples `out_top_pc`/`out_top_flags` and asserts `in_pop` in the same cycle.
  - The sampled values are valid before the edge that removes them.
- `call` needs a single cycle with `in_push`. Back-to-back pushes and pops are supported every cycle.
- Reset (asynchronous assert, synchronous deassert handled externally):
  - `sp`=0, `out_empty`=1, `out_full`=0.
  - `out_depth`=0, both errors 0, top outputs 0.
- A reset mid-sequence discards all entries immediately, with no partial state.

## Structure
- Shared package `drfa_pkg`:
  - `PC_WIDTH`, `FLAGS_WIDTH`, `CALL_DEPTH` (=5).
  - A packed struct `stack_entry_t` {pc, flags}. The control unit and this block both use it.
- No sub-module is needed. A single module contains the register array, the `sp` counter and the error flags.
- Expected size: about 130 lines of RTL.

## Test plan
- Reset then idle:
  - Required: `out_empty`=1, `out_depth`=0, top=0/0, errors 0.
- Fill:
  - Stimulus: push pc 0x10..0x14 with flags 1..5 over 5 cycles.
  - Required: `out_full`=1, depth=5, top=0x14/5.
  - Then a 6th push of 0x20: `out_overflow`=1 and top stays 0x14/5.
- Drain:
  - Stimulus: 5 pops.
  - Required: top reads 0x14, 0x13, 0x12, 0x11, 0x10 before each edge. Then `out_empty`=1.
  - Then an extra pop: `out_underflow`=1 and depth stays 0.
- Simultaneous push and pop:
  - Depth 2 (top 0x11/2), push 0x30/7 with pop: depth=2, top=0x30/7, no error.
  - Empty, push 0x40/3 with pop: depth=1, top=0x40/3, `out_underflow`=1.
- Clear:
  - Stimulus: with depth 3 and both errors set, pulse `in_clear` together with `in_push`.
  - Required: depth=0, errors 0, and the push is ignored.
- Asynchronous reset mid-sequence:
  - Stimulus: drop `rst_n` between edges at depth 4.
  - Required: outputs go to reset values without waiting for a clock edge. The next push of 0x55 gives depth=1, top=0x55.

Source files
------------

// File: rtl/drfa_pkg.sv
// drfa_pkg: shared widths and the call-stack entry layout used by the control unit and call_stack.
package drfa_pkg;
  localparam int PC_WIDTH    = 8;
  localparam int FLAGS_WIDTH = 4;
  localparam int CALL_DEPTH  = 5;
  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [FLAGS_WIDTH-1:0] flags;
  } stack_entry_t;
endpackage

// File: rtl/call_stack.sv
// call_stack: return stack of {pc, flags} for call/ret with saturating sp and sticky overflow/underflow.
module call_stack #(
  parameter int DEPTH       = drfa_pkg::CALL_DEPTH,
  parameter int PC_WIDTH    = drfa_pkg::PC_WIDTH,
  parameter int FLAGS_WIDTH = drfa_pkg::FLAGS_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_push,
  input  logic                       in_pop,
  input  logic                       in_clear,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [FLAGS_WIDTH-1:0]     in_flags,
  output logic [PC_WIDTH-1:0]        out_top_pc,
  output logic [FLAGS_WIDTH-1:0]     out_top_flags,
  output logic [$clog2(DEPTH+1)-1:0] out_depth,
  output logic                       out_empty,
  output logic                       out_full,
  output logic                       out_overflow,
  output logic                       out_underflow
);
  localparam int SW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [FLAGS_WIDTH-1:0] flags;
  } entry_t;
  entry_t          mem [DEPTH];
  logic [SW-1:0]   sp, sp_nxt;
  logic            ovf, ovf_nxt, udf, udf_nxt;
  logic            empty, full, wr_en;
  logic [AW-1:0]   top_idx, wr_idx;
  entry_t          top;
  assign empty   = sp == '0;
  assign full    = sp == SW'(DEPTH);
  assign top_idx = AW'(sp - SW'(1));
  assign top     = empty ? '0 : mem[top_idx];
  always_comb begin
    wr_en   = ~in_clear & in_push & (in_pop | ~full);
    // push+pop on a non-empty stack overwrites the top in place
    wr_idx  = (in_pop & ~empty) ? top_idx : AW'(sp);
    sp_nxt  = in_clear                       ? '0 :
              in_push & ~in_pop & ~full      ? sp + SW'(1) :
              in_pop & ~in_push & ~empty     ? sp - SW'(1) :
              in_push & in_pop & empty       ? SW'(1) : sp;
    ovf_nxt = ~in_clear & (ovf | (in_push & ~in_pop & full));
    udf_nxt = ~in_clear & (udf | (in_pop & empty));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      sp  <= sp_nxt;
      ovf <= ovf_nxt;
      udf <= udf_nxt;
    end
  end
  // entry contents are don't-care beyond sp, so the array needs no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= '{pc: in_pc, flags: in_flags};
  end
  assign out_top_pc    = top.pc;
  assign out_top_flags = top.flags;
  assign out_depth     = sp;
  assign out_empty     = empty;
  assign out_full      = full;
  assign out_overflow  = ovf;
  assign out_underflow = udf;
endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: directed scoreboard bench for call_stack with the default 5-entry configuration.
module tb_call_stack;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_push = 1'b0, in_pop = 1'b0, in_clear = 1'b0;
  logic [7:0] in_pc = '0;
  logic [3:0] in_flags = '0;
  logic [7:0] out_top_pc;
  logic [3:0] out_top_flags;
  logic [2:0] out_depth;
  logic       out_empty, out_full, out_overflow, out_underflow;
  logic [18:0] exp_q [$];
  logic [18:0] exp_v, obs_v;
  int checks = 0;
  int failures = 0;

  call_stack dut (
    .clk(clk), .rst_n(rst_n), .in_push(in_push), .in_pop(in_pop), .in_clear(in_clear),
    .in_pc(in_pc), .in_flags(in_flags), .out_top_pc(out_top_pc), .out_top_flags(out_top_flags),
    .out_depth(out_depth), .out_empty(out_empty), .out_full(out_full),
    .out_overflow(out_overflow), .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  task automatic expect_s(input logic [7:0] pc, input logic [3:0] fl, input logic [2:0] d,
                          input logic ovf, input logic udf);
    exp_q.push_back({pc, fl, d, d == 3'd0, d == 3'd5, ovf, udf});
  endtask

  task automatic check(input string tag);
    obs_v = {out_top_pc, out_top_flags, out_depth, out_empty, out_full, out_overflow, out_underflow};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs_v);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs_v === exp_v) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h (pc,flags,depth,empty,full,ovf,udf)", tag, obs_v, exp_v);
      end
    end
  endtask

  task automatic step(input logic push, input logic pop, input logic clr,
                      input logic [7:0] pc, input logic [3:0] fl);
    @(negedge clk);
    in_push = push; in_pop = pop; in_clear = clr; in_pc = pc; in_flags = fl;
    @(posedge clk);
    #1;
    in_push = 1'b0; in_pop = 1'b0; in_clear = 1'b0;
  endtask

  initial begin
    #12;
    expect_s(8'h00, 4'd0, 3'd0, 1'b0, 1'b0); check("reset");
    @(negedge clk); rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'hAA, 4'hA);
    expect_s(8'h00, 4'd0, 3'd0, 1'b0, 1'b0); check("idle");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), 4'(i + 1));
      expect_s(8'(8'h10 + i), 4'(i + 1), 3'(i + 1), 1'b0, 1'b0); check("fill");
    end
    step(1'b1, 1'b0, 1'b0, 8'h20, 4'h9);
    expect_s(8'h14, 4'd5, 3'd5, 1'b1, 1'b0); check("overflow");
    for (int i = 0; i < 5; i++) begin
      expect_s(8'(8'h14 - i), 4'(5 - i), 3'(5 - i), 1'b1, 1'b0); check("drain_pre_edge");
      step(1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    end
    expect_s(8'h00, 4'd0, 3'd0, 1'b1, 1'b0); check("drained");
    step(1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    expect_s(8'h00, 4'd0, 3'd0, 1'b1, 1'b1); check("underflow");
    step(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
    expect_s(8'h00, 4'd0, 3'd0, 1'b0, 1'b0); check("clear_errors");
    step(1'b1, 1'b0, 1'b0, 8'h10, 4'd1);
    step(1'b1, 1'b0, 1'b0, 8'h11, 4'd2);
    expect_s(8'h11, 4'd2, 3'd2, 1'b0, 1'b0); check("depth2");
    step(1'b1, 1'b1, 1'b0, 8'h30, 4'd7);
    expect_s(8'h30, 4'd7, 3'd2, 1'b0, 1'b0); check("push_pop_replace");
    step(1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    expect_s(8'h10, 4'd1, 3'd1, 1'b0, 1'b0); check("replace_kept_below");
    step(1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    step(1'b1, 1'b1, 1'b0, 8'h40, 4'd3);
    expect_s(8'h40, 4'd3, 3'd1, 1'b0, 1'b1); check("push_pop_empty");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h50 + i), 4'(i));
    step(1'b1, 1'b1, 1'b0, 8'h77, 4'hE);
    expect_s(8'h77, 4'hE, 3'd5, 1'b0, 1'b1); check("push_pop_full");
    step(1'b1, 1'b0, 1'b0, 8'h88, 4'h8);
    step(1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
    expect_s(8'h51, 4'd1, 3'd3, 1'b1, 1'b1); check("pre_clear");
    step(1'b1, 1'b0, 1'b1, 8'h99, 4'h9);
    expect_s(8'h00, 4'd0, 3'd0, 1'b0, 1'b0); check("clear_with_push");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i), 4'(i + 4));
    expect_s(8'h63, 4'd7, 3'd4, 1'b0, 1'b0); check("depth4");
    #1 rst_n = 1'b0;
    #1;
    expect_s(8'h00, 4'd0, 3'd0, 1'b0, 1'b0); check("async_reset");
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h55, 4'h2);
    expect_s(8'h55, 4'h2, 3'd1, 1'b0, 1'b0); check("after_reset_push");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
